// File: rtl/signed_divide_by_power_of_2_serial.sv
// Serial signed divide by 2^s with round-toward-zero (C-style / and %).
// One arithmetic shift per clock; quotient and remainder are fixed up in a single FIX cycle.
module signed_divide_by_power_of_2_serial #(
  parameter int N  = 8,
  parameter int SW = $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arg_vld,
  output logic                arg_rdy,
  input  logic signed [N-1:0] a,
  input  logic [SW-1:0]       s,
  output logic                res_vld,
  input  logic                res_rdy,
  output logic signed [N-1:0] q,
  output logic signed [N-1:0] r
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic signed [N-1:0] acc;
  logic [N-1:0]        low;
  logic [SW-1:0]       cnt;
  logic [SW-1:0]       sh;
  logic                neg;
  logic [SW-1:0]       s_eff;

  function automatic logic [SW-1:0] sat_count(input logic [SW-1:0] x);
    return (x > SW'(N)) ? SW'(N) : x;
  endfunction

  // A negative dividend with nonzero discarded bits was floored; step back toward zero.
  function automatic logic [N-1:0] round_q(input logic [N-1:0] fl, input logic ng,
                                           input logic [N-1:0] lo);
    return (ng && lo != '0) ? fl + N'(1) : fl;
  endfunction

  // Done in N+1 bits so that 2^N is representable when the whole word was shifted out.
  function automatic logic [N-1:0] round_r(input logic ng, input logic [N-1:0] lo,
                                           input logic [SW-1:0] amt);
    logic [N:0] one;
    logic [N:0] diff;
    one  = 1;
    diff = {1'b0, lo} - (one << amt);
    return (ng && lo != '0) ? diff[N-1:0] : lo;
  endfunction

  assign s_eff = sat_count(s);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arg_vld) state_nxt = (s_eff != '0) ? SHIFT : FIX;
      SHIFT:   if (cnt == SW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arg_rdy = (state == IDLE);
    res_vld = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      low <= '0;
      cnt <= '0;
      sh  <= '0;
      neg <= 1'b0;
      q   <= '0;
      r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arg_vld) begin
            acc <= a;
            cnt <= s_eff;
            sh  <= s_eff;
            neg <= a[N-1];
            low <= '0;
          end
        end
        SHIFT: begin
          // The bit leaving acc lands at its original position in low.
          acc <= {acc[N-1], acc[N-1:1]};
          low <= low | (N'(acc[0]) << (sh - cnt));
          cnt <= cnt - SW'(1);
        end
        FIX: begin
          q <= round_q(acc, neg, low);
          r <= round_r(neg, low, sh);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divide_by_power_of_2_serial.sv
// Scoreboard bench for signed_divide_by_power_of_2_serial (N=8): directed cases,
// backpressure, mid-operation reset and an exhaustive a/s sweep.
module tb_signed_divide_by_power_of_2_serial;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       arg_vld;
  logic       arg_rdy;
  logic [7:0] a;
  logic [3:0] s;
  logic       res_vld;
  logic       res_rdy;
  logic [7:0] q;
  logic [7:0] r;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  signed_divide_by_power_of_2_serial #(.N(8), .SW(4)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .s(s),
    .res_vld(res_vld), .res_rdy(res_rdy), .q(q), .r(r)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] eq, input logic [7:0] er, input int lat);
    exp_t e;
    e.q = eq; e.r = er; e.lat = lat;
    return e;
  endfunction

  // C semantics: integer / truncates toward zero, % takes the sign of the dividend.
  function automatic exp_t model(input logic [7:0] av, input int sv);
    int se, d, ai, qi, ri;
    se = (sv > 8) ? 8 : sv;
    d  = 1 << se;
    ai = $signed(av);
    qi = ai / d;
    ri = ai % d;
    return mk(qi[7:0], ri[7:0], se + 1);
  endfunction

  task automatic apply(input logic [7:0] av, input logic [3:0] sv, input exp_t e);
    int n = 0;
    @(negedge clk);
    a = av; s = sv; arg_vld = 1'b1;
    while (!arg_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 arg_vld = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!res_vld && lat < 40);
    if (!res_vld) begin
      vectors++; miscompares++;
      $display("FAIL result_timeout res_vld=0 required=1 after %0d cycles", lat);
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    res_rdy = 1'b1;
    @(posedge clk);
    #1 res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b0; a = '0; s = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if (arg_rdy !== 1'b1 || res_vld !== 1'b0 || q !== 8'h00 || r !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state arg_rdy=%b res_vld=%b q=%h r=%h required 1 0 00 00",
               arg_rdy, res_vld, q, r);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [12] = '{8'hF3, 8'h0D, 8'hF8, 8'h64, 8'h80, 8'h80, 8'h80, 8'h80,
                            8'h7F, 8'hFF, 8'hFF, 8'h01};
    logic [3:0] ts [12] = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd7, 4'd8, 4'd15,
                            4'd8, 4'd1, 4'd0, 4'd1};
    logic [7:0] tq [12] = '{8'hFD, 8'h03, 8'hFF, 8'h0C, 8'h80, 8'hFF, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'hFF, 8'h00};
    logic [7:0] tr [12] = '{8'hFF, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h80, 8'h80,
                            8'h7F, 8'hFF, 8'h00, 8'h01};
    int         tl [12] = '{3, 3, 4, 4, 1, 8, 9, 9, 9, 2, 1, 2};
    for (int i = 0; i < 12; i++) begin
      int   lat;
      exp_t e;
      apply(ta[i], ts[i], mk(tq[i], tr[i], tl[i]));
      wait_result(lat);
      e = sb.pop_front();
      vectors++;
      if (q !== e.q || r !== e.r) begin
        miscompares++;
        $display("FAIL directed_qr a=%h s=%0d q=%h r=%h required q=%h r=%h",
                 ta[i], ts[i], q, r, e.q, e.r);
      end
      vectors++;
      if (lat !== e.lat) begin
        miscompares++;
        $display("FAIL directed_latency a=%h s=%0d latency=%0d required=%0d",
                 ta[i], ts[i], lat, e.lat);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    apply(8'hF3, 4'd2, mk(8'hFD, 8'hFF, 3));
    wait_result(lat);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      arg_vld = ~arg_vld;
      a = 8'($urandom);
      s = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      vectors++;
      if (res_vld !== 1'b1 || arg_rdy !== 1'b0 || q !== e.q || r !== e.r) begin
        miscompares++;
        $display("FAIL backpressure_hold cyc=%0d res_vld=%b arg_rdy=%b q=%h r=%h required 1 0 %h %h",
                 i, res_vld, arg_rdy, q, r, e.q, e.r);
      end
    end
    @(negedge clk);
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    @(posedge clk);
    #1 res_rdy = 1'b0;
    vectors++;
    if (res_vld !== 1'b0 || arg_rdy !== 1'b1 || q !== e.q || r !== e.r) begin
      miscompares++;
      $display("FAIL backpressure_release res_vld=%b arg_rdy=%b q=%h r=%h required 0 1 %h %h",
               res_vld, arg_rdy, q, r, e.q, e.r);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (res_vld !== 1'b0 || arg_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_idle res_vld=%b arg_rdy=%b required 0 1", res_vld, arg_rdy);
    end
  endtask

  task automatic test_reset_midop();
    int   lat;
    int   pulses = 0;
    exp_t e;
    apply(8'hB7, 4'd5, mk(8'h00, 8'h00, 0));
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if (arg_rdy !== 1'b1 || res_vld !== 1'b0 || q !== 8'h00 || r !== 8'h00) begin
      miscompares++;
      $display("FAIL midop_reset arg_rdy=%b res_vld=%b q=%h r=%h required 1 0 00 00",
               arg_rdy, res_vld, q, r);
    end
    repeat (10) begin
      @(posedge clk);
      #1 if (res_vld) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL midop_no_result res_vld_cycles=%0d required=0", pulses);
    end
    apply(8'h64, 4'd3, mk(8'h0C, 8'h04, 4));
    wait_result(lat);
    e = sb.pop_front();
    vectors++;
    if (q !== e.q || r !== e.r || lat !== e.lat) begin
      miscompares++;
      $display("FAIL midop_followup q=%h r=%h latency=%0d required q=%h r=%h latency=%0d",
               q, r, lat, e.q, e.r, e.lat);
    end
    release_result();
  endtask

  task automatic test_sweep();
    for (int ai = -128; ai < 128; ai++) begin
      for (int sv = 0; sv <= 10; sv++) begin
        int         lat, se, qs, rs;
        logic [7:0] av;
        exp_t       e;
        av = ai[7:0];
        apply(av, sv[3:0], model(av, sv));
        wait_result(lat);
        e = sb.pop_front();
        vectors++;
        if (q !== e.q || r !== e.r || lat !== e.lat) begin
          miscompares++;
          $display("FAIL sweep a=%0d s=%0d q=%h r=%h latency=%0d required q=%h r=%h latency=%0d",
                   ai, sv, q, r, lat, e.q, e.r, e.lat);
        end
        se = (sv > 8) ? 8 : sv;
        qs = $signed(q);
        rs = $signed(r);
        vectors++;
        if (qs * (1 << se) + rs !== ai) begin
          miscompares++;
          $display("FAIL sweep_identity a=%0d s=%0d q*2^s+r=%0d required=%0d",
                   ai, sv, qs * (1 << se) + rs, ai);
        end
        release_result();
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/signed_divide_by_power_of_2_serial.md
# signed_divide_by_power_of_2_serial

Multi-cycle signed divider by a run-time power of two. It sits directly downstream of the fixed arithmetic-right-shift stage and extends it in two ways. It takes a variable shift count, and it rounds toward zero, as C-style `/` and `%` do, instead of flooring as `>>>` does. Operands and results move over valid/ready handshakes, and the block shifts one bit per clock so the datapath stays a single N-bit register.

## Interface
- `N`, default 8: operand and result width, signed two's complement. N ≥ 2.
- `SW`, default `$clog2(N)+1`: width of the shift-count port. It must be able to represent N.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `arg_vld` input 1: `a`/`s` are valid.
- `arg_rdy` output 1: the block can accept an operand.
- `a` input N: signed dividend.
- `s` input SW: unsigned shift count. The divisor is 2^s.
- `res_vld` output 1: `q`/`r` are valid.
- `res_rdy` input 1: the consumer accepts the result.
- `q` output N: signed quotient, trunc(a / 2^s).
- `r` output N: signed remainder, a − q·2^s. It is zero or has the sign of `a`.

## Operation
- States: IDLE, SHIFT, FIX, DONE.
- Effective count: `s_eff = min(s, N)`. Counts above N saturate to N.
- **IDLE**
  - `arg_rdy=1`.
  - On `arg_vld && arg_rdy`, latch:
    - `acc=a`
    - `cnt=s_eff`
    - `neg=a[N-1]`
    - `low=0`, where `low` is an N-bit register that collects the shifted-out bits.
  - Next state is SHIFT if `s_eff>0`, else FIX.
- **SHIFT**, once per cycle:
  - `acc = {acc[N-1], acc[N-1:1]}`, a 1-bit arithmetic shift built with concatenation.
  - `low` collects `acc[0]`, so that after s_eff steps `low` equals the unsigned `a & (2^s_eff − 1)`.
  - `cnt` decrements.
  - Leave for FIX on the cycle `cnt` reaches 1, after the last shift.
- **FIX**, one cycle. At this point `acc` holds floor(a/2^s_eff).
  - If `neg && low!=0`: `q = acc + 1` and `r = low − 2^s_eff`. The subtraction is done in N+1 bits and truncated to N; for s_eff=N this gives `r=a`.
  - Otherwise: `q = acc` and `r = low`.
  - Register `q`/`r`, set `res_vld`, go to DONE.
- **DONE**
  - `res_vld=1`. `q` and `r` are held stable.
  - On `res_rdy`: clear `res_vld` and go to IDLE.
  - `arg_rdy=0` in DONE, so a new operand is never accepted in the same cycle a result leaves.
- `arg_rdy` is 0 in SHIFT, FIX and DONE. `arg_vld`, `a` and `s` are ignored there.
- All arithmetic is two's complement modulo 2^N. No overflow is possible: |q| ≤ |a| and |r| < 2^s_eff.
- Special cases:
  - `s_eff=0`: q=a, r=0.
  - `s_eff=N`: q=0, r=a for any a, including a=−2^(N−1).

## Timing
- Reset values: `arg_rdy=1`, `res_vld=0`, `q=0`, `r=0`, state IDLE, all internal registers 0.
- Reset mid-operation, in any state, aborts without producing a result. The cycle after the reset edge shows `arg_rdy=1` and `res_vld=0`.
- Latency: with the accept edge as E0, `res_vld` is high after edge E(s_eff+1). That is 1 cycle for s=0 and N+1 cycles at most.
- Throughput: one operation per s_eff+3 cycles when `res_rdy` is held high. The extra cycles are the DONE handshake and the IDLE re-accept.
- `q`/`r` change only on the FIX→DONE edge and when resetting. They keep their last value after the result is consumed.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- N=8, a=0xF3 (−13), s=2: q=0xFD (−3), r=0xFF (−1); `res_vld` rises 3 edges after accept. Contrast: `>>>` would give −4.
- a=0x0D (13), s=2: q=0x03, r=0x01. Exact-negative case a=0xF8 (−8), s=3: q=0xFF, r=0x00, with no FIX increment.
- Boundaries on a=0x80:
  - s=0: q=0x80, r=0x00, latency 1.
  - s=7: q=0xFF, r=0x00.
  - s=8: q=0x00, r=0x80.
  - s=15: same as s=8 (saturation).
- Backpressure: hold `res_rdy=0` for 5 cycles in DONE while toggling `arg_vld` and `a`. Required: q/r stable, `arg_rdy=0`, no operand accepted. After `res_rdy=1`: `res_vld=0`, and `arg_rdy=1` the next cycle.
- Reset mid-operation: assert `rst` for one cycle during SHIFT with s=5. Required: no `res_vld` pulse; `arg_rdy=1`, q=r=0 after reset. A follow-up a=0x64 (100), s=3 yields q=0x0C, r=0x04.
- Randomized sweep, all a in [−128,127] and s in [0,10]: q equals C-style a/2^s_eff and r equals a%2^s_eff, with `q*2^s_eff + r == a` checked by the scoreboard.
